// File: rtl/data_pump_master.sv
// rtl/data_pump_master.sv - SPI master driving the data_io download protocol (ping, index, [status], stream, end)
//
// Ports:
//   clk_sys, rst_n           clock, asynchronous active-low reset
//   start, index, length     transfer request; index/length latched when accepted
//   s_data, s_valid, s_ready payload byte stream; s_ready is high in the cycle a byte is taken
//   SPI_SCK, SPI_SS2, SPI_DI SPI mode-0 master outputs (MSB first)
//   SPI_DO                   SPI input from the slave
//   busy, done, ack_err      status: in progress, one-cycle success pulse, sticky ping failure
//   status_word, core_mod    only with DATA_PUMP_STATUS_EN: sent in a 0x15 frame after INDEX
//
// Optional feature macro: DATA_PUMP_STATUS_EN
module data_pump_master #(
    parameter int          CLKDIV  = 2,
    parameter int          GAP     = 4,
    parameter logic [7:0]  ACK_VAL = 8'h4B
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
`ifdef DATA_PUMP_STATUS_EN
    input  logic [31:0] status_word,
    input  logic [6:0]  core_mod,
`endif
    output logic        SPI_SCK,
    output logic        SPI_SS2,
    output logic        SPI_DI,
    input  logic        SPI_DO,
    output logic        busy,
    output logic        done,
    output logic        ack_err
);

    // Frame-level FSM position (which protocol frame is on the wire)
    typedef enum logic [2:0] {F_PING, F_INDEX, F_STATUS, F_STREAM, F_END} frame_t;
    // Bit-level phase inside / between frames
    typedef enum logic [2:0] {P_IDLE, P_LOW, P_HIGH, P_STALL, P_TAIL, P_GAP, P_DONE} phase_t;

    phase_t      phase, phase_n;
    frame_t      frame, frame_n;
    logic [15:0] tmr, tmr_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [2:0]  byte_cnt, byte_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  rx, rx_n;
    logic [24:0] remaining, rem_n;
    logic [7:0]  idx_r, idx_n;
    logic        sck_q, sck_n;
    logic        ss2_q, ss2_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        err_q, err_n;
    logic        have_next;
    logic [7:0]  next_data;
`ifdef DATA_PUMP_STATUS_EN
    logic [31:0] st_r, st_n;
    logic [6:0]  cm_r, cm_n;
`endif

    function automatic logic [7:0] frame_cmd(input frame_t f);
        case (f)
            F_PING:   frame_cmd = 8'h00;
            F_INDEX:  frame_cmd = 8'h55;
            F_STATUS: frame_cmd = 8'h15;
            F_STREAM: frame_cmd = 8'h61;
            default:  frame_cmd = 8'h62;
        endcase
    endfunction

    // MOSI is the shift register MSB; it is cleared whenever no byte is pending
    assign SPI_DI  = shift[7];
    assign SPI_SCK = sck_q;
    assign SPI_SS2 = ss2_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = err_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= P_IDLE;
            frame     <= F_PING;
            tmr       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            rx        <= '0;
            remaining <= '0;
            idx_r     <= '0;
            sck_q     <= 1'b0;
            ss2_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DATA_PUMP_STATUS_EN
            st_r      <= '0;
            cm_r      <= '0;
`endif
        end else begin
            phase     <= phase_n;
            frame     <= frame_n;
            tmr       <= tmr_n;
            bit_cnt   <= bit_n;
            byte_cnt  <= byte_n;
            shift     <= shift_n;
            rx        <= rx_n;
            remaining <= rem_n;
            idx_r     <= idx_n;
            sck_q     <= sck_n;
            ss2_q     <= ss2_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
`ifdef DATA_PUMP_STATUS_EN
            st_r      <= st_n;
            cm_r      <= cm_n;
`endif
        end
    end

    always_comb begin
        phase_n   = phase;
        frame_n   = frame;
        tmr_n     = tmr;
        bit_n     = bit_cnt;
        byte_n    = byte_cnt;
        shift_n   = shift;
        rx_n      = rx;
        rem_n     = remaining;
        idx_n     = idx_r;
        sck_n     = sck_q;
        ss2_n     = ss2_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        err_n     = err_q;
        s_ready   = 1'b0;
        have_next = 1'b0;
        next_data = 8'h00;
`ifdef DATA_PUMP_STATUS_EN
        st_n      = st_r;
        cm_n      = cm_r;
`endif

        // Follow-on byte for fixed-content frames; byte_cnt is the byte just finished
        case (frame)
            F_PING:  have_next = (byte_cnt == 3'd0);
            F_INDEX: begin
                have_next = (byte_cnt == 3'd0);
                next_data = idx_r;
            end
`ifdef DATA_PUMP_STATUS_EN
            F_STATUS: begin
                have_next = (byte_cnt < 3'd5);
                case (byte_cnt)
                    3'd0:    next_data = st_r[31:24];
                    3'd1:    next_data = st_r[23:16];
                    3'd2:    next_data = st_r[15:8];
                    3'd3:    next_data = st_r[7:0];
                    default: next_data = {1'b0, cm_r};
                endcase
            end
`endif
            default: have_next = 1'b0;
        endcase

        case (phase)
            P_IDLE, P_DONE: begin
                phase_n = P_IDLE;
                if (start) begin
                    idx_n   = index;
                    rem_n   = length;
`ifdef DATA_PUMP_STATUS_EN
                    st_n    = status_word;
                    cm_n    = core_mod;
`endif
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
                    frame_n = F_PING;
                    byte_n  = '0;
                    bit_n   = '0;
                    shift_n = frame_cmd(F_PING);
                    ss2_n   = 1'b0;
                    tmr_n   = 16'(CLKDIV - 1);
                    phase_n = P_LOW;
                end
            end
            P_LOW: begin
                if (tmr == '0) begin
                    sck_n   = 1'b1;
                    rx_n    = {rx[6:0], SPI_DO};
                    tmr_n   = 16'(CLKDIV - 1);
                    phase_n = P_HIGH;
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            P_HIGH: begin
                if (tmr == '0) begin
                    sck_n = 1'b0;
                    tmr_n = 16'(CLKDIV - 1);
                    if (bit_cnt != 3'd7) begin
                        bit_n   = bit_cnt + 3'd1;
                        shift_n = {shift[6:0], 1'b0};
                        phase_n = P_LOW;
                    end else begin
                        bit_n  = '0;
                        byte_n = byte_cnt + 3'd1;
                        if (frame == F_STREAM) begin
                            shift_n = 8'h00;
                            phase_n = (remaining == '0) ? P_TAIL : P_STALL;
                        end else if (have_next) begin
                            shift_n = next_data;
                            phase_n = P_LOW;
                        end else begin
                            shift_n = 8'h00;
                            phase_n = P_TAIL;
                        end
                    end
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            P_STALL: begin
                // Byte boundary inside the stream frame: SCK low, SS2 low until data arrives
                s_ready = s_valid;
                if (s_valid) begin
                    shift_n = s_data;
                    rem_n   = remaining - 25'd1;
                    tmr_n   = 16'(CLKDIV - 1);
                    phase_n = P_LOW;
                end
            end
            P_TAIL: begin
                if (tmr == '0) begin
                    ss2_n   = 1'b1;
                    tmr_n   = 16'(GAP - 1);
                    phase_n = P_GAP;
                    case (frame)
                        F_PING: begin
                            if (rx != ACK_VAL) begin
                                err_n   = 1'b1;
                                busy_n  = 1'b0;
                                phase_n = P_IDLE;
                            end else begin
                                frame_n = F_INDEX;
                            end
                        end
`ifdef DATA_PUMP_STATUS_EN
                        F_INDEX:  frame_n = F_STATUS;
                        F_STATUS: frame_n = F_STREAM;
`else
                        F_INDEX:  frame_n = F_STREAM;
`endif
                        F_STREAM: frame_n = F_END;
                        default: begin
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            phase_n = P_DONE;
                        end
                    endcase
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            P_GAP: begin
                if (tmr == '0) begin
                    ss2_n   = 1'b0;
                    shift_n = frame_cmd(frame);
                    byte_n  = '0;
                    bit_n   = '0;
                    tmr_n   = 16'(CLKDIV - 1);
                    phase_n = P_LOW;
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end
            default: phase_n = P_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_pump_master.sv
// tb/tb_data_pump_master.sv - self-checking bench for data_pump_master with a behavioral data_io slave
module tb_data_pump_master;

    localparam int CLKDIV = 2;
    localparam int GAP    = 4;
`ifdef DATA_PUMP_STATUS_EN
    localparam int NST = 1;
`else
    localparam int NST = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  index   = 8'h00;
    logic [24:0] length  = '0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        SPI_SCK, SPI_SS2, SPI_DI;
    logic        SPI_DO = 1'b0;
    logic        busy, done, ack_err;
`ifdef DATA_PUMP_STATUS_EN
    logic [31:0] status_word = 32'h12345678;
    logic [6:0]  core_mod    = 7'h05;
`endif

    data_pump_master #(.CLKDIV(CLKDIV), .GAP(GAP), .ACK_VAL(8'h4B)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .index(index), .length(length),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef DATA_PUMP_STATUS_EN
        .status_word(status_word), .core_mod(core_mod),
`endif
        .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI), .SPI_DO(SPI_DO),
        .busy(busy), .done(done), .ack_err(ack_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- payload producer and output monitor ----------------
    logic [7:0] payload [16];
    int plen       = 0;
    int stall_idx  = -1;
    int rdy_base   = 0;
    int rdy_cnt    = 0;
    int done_cnt   = 0;
    int done_busy  = 0;
    int stall_cnt  = 0;
    int stall_samp = 0;
    int stall_bad  = 0;
    int ptr        = 0;

    always begin
        @(negedge clk_sys);
        if (s_ready) rdy_cnt++;
        if (done) begin
            done_cnt++;
            if (busy) done_busy++;
        end
        // Late part of the stall: byte 1 has finished shifting, DUT must be parked
        if (ptr == stall_idx && stall_cnt >= 36 && stall_cnt <= 50 && busy) begin
            stall_samp++;
            if (SPI_SCK || SPI_SS2) stall_bad++;
        end
        @(posedge clk_sys);
        #1;
        ptr = rdy_cnt - rdy_base;
        if (ptr == stall_idx) stall_cnt++;
        else stall_cnt = 0;
        s_valid = (ptr < plen) && !(ptr == stall_idx && stall_cnt <= 50);
        s_data  = payload[ptr[3:0]];
    end

    // ---------------- behavioral data_io slave ----------------
    logic [7:0]  fb [16][8];
    int          flen [16];
    int          nframes = 0;
    int          wr_a [16];
    logic [7:0]  wr_d [16];
    int          nwr = 0;
    int          sl_addr = 0;
    logic [31:0] st_rx = '0;
    logic [6:0]  cm_rx = '0;
    logic [7:0]  sl_sh = '0, sl_tx = '0, sl_next = '0;
    int          sl_bits = 0, cur = 0;
    logic        p_sck = 1'b0, p_ss = 1'b1, p_clr = 1'b0;
    logic        clr_tgl = 1'b0;
    logic [7:0]  ack_resp = 8'h4B;

    always begin
        @(SPI_SCK or SPI_SS2 or clr_tgl);
        if (clr_tgl != p_clr) begin
            nframes = 0; nwr = 0; sl_addr = 0; st_rx = '0; cm_rx = '0;
        end
        if (p_ss && !SPI_SS2) begin
            cur = (nframes < 16) ? nframes : 15;
            if (nframes < 16) nframes++;
            flen[cur] = 0; sl_bits = 0; sl_tx = 8'h00; sl_next = 8'h00;
            SPI_DO = 1'b0;
        end
        if (!SPI_SS2 && !p_sck && SPI_SCK) begin
            sl_sh = {sl_sh[6:0], SPI_DI};
            sl_bits++;
            if (sl_bits == 8) begin
                sl_bits = 0;
                if (flen[cur] < 8) fb[cur][flen[cur]] = sl_sh;
                if (flen[cur] == 0) begin
                    sl_next = (sl_sh == 8'h00) ? ack_resp : 8'h00;
                end else begin
                    sl_next = 8'h00;
                    case (fb[cur][0])
                        8'h55: sl_addr = 0;
                        8'h61: begin
                            if (nwr < 16) begin
                                wr_a[nwr] = sl_addr; wr_d[nwr] = sl_sh; nwr++;
                            end
                            sl_addr++;
                        end
                        8'h15: begin
                            if (flen[cur] <= 4) st_rx = {st_rx[23:0], sl_sh};
                            else cm_rx = sl_sh[6:0];
                        end
                        default: ;
                    endcase
                end
                flen[cur]++;
            end
        end
        if (!SPI_SS2 && p_sck && !SPI_SCK) begin
            if (sl_bits == 0) sl_tx = sl_next;
            else sl_tx = {sl_tx[6:0], 1'b0};
            SPI_DO = sl_tx[7];
        end
        p_sck = SPI_SCK; p_ss = SPI_SS2; p_clr = clr_tgl;
    end

    // ---------------- sequencing helpers ----------------
    int done_base = 0;

    task automatic start_xfer(input logic [7:0] idx, input int len, input logic [7:0] ack, input int stall);
        clr_tgl   = ~clr_tgl;
        ack_resp  = ack;
        plen      = len;
        stall_idx = stall;
        rdy_base  = rdy_cnt;
        done_base = done_cnt;
        index     = idx;
        length    = 25'(len);
        @(posedge clk_sys); #1 start = 1'b1;
        @(posedge clk_sys); #1 start = 1'b0;
        @(negedge clk_sys);
        chk("busy_after_start", 32'(busy), 1);
        chk("ack_err_cleared_on_start", 32'(ack_err), 0);
        // Inputs changed and start re-pulsed while busy must not affect this transfer
        repeat (20) @(posedge clk_sys);
        #1 index = ~idx; length = 25'd5; start = 1'b1;
        @(posedge clk_sys); #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 6000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("xfer_finished_in_time", 32'(n < 6000), 1);
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic check_xfer(input logic [7:0] idx, input int len, input logic exp_err,
                              input int exp_frames, input int exp_rdy, input int exp_done);
        int sf;
        chk("frame_count", nframes, exp_frames);
        chk("ack_err_end", 32'(ack_err), 32'(exp_err));
        chk("busy_end", 32'(busy), 0);
        chk("done_pulses", done_cnt - done_base, exp_done);
        chk("s_ready_pulses", rdy_cnt - rdy_base, exp_rdy);
        chk("done_with_busy_low", done_busy, 0);
        chk("ping_len", flen[0], 2);
        chk("ping_b0", 32'(fb[0][0]), 32'h00);
        chk("ping_b1", 32'(fb[0][1]), 32'h00);
        if (!exp_err) begin
            chk("index_len", flen[1], 2);
            chk("index_b0", 32'(fb[1][0]), 32'h55);
            chk("index_b1", 32'(fb[1][1]), 32'(idx));
`ifdef DATA_PUMP_STATUS_EN
            chk("status_len", flen[2], 6);
            chk("status_cmd", 32'(fb[2][0]), 32'h15);
            chk("status_b5", 32'(fb[2][5]), 32'h05);
            chk("slave_status", 32'(st_rx), 32'h12345678);
            chk("slave_core_mod", 32'(cm_rx), 32'h05);
`endif
            sf = 2 + NST;
            chk("stream_len", flen[sf], len + 1);
            chk("stream_cmd", 32'(fb[sf][0]), 32'h61);
            chk("slave_writes", nwr, len);
            for (int i = 0; i < nwr && i < 8; i++) begin
                chk($sformatf("stream_b%0d", i + 1), 32'(fb[sf][i + 1]), 32'(payload[i]));
                chk($sformatf("wr_addr%0d", i), wr_a[i], i);
                chk($sformatf("wr_data%0d", i), 32'(wr_d[i]), 32'(payload[i]));
            end
            chk("end_len", flen[sf + 1], 1);
            chk("end_cmd", 32'(fb[sf + 1][0]), 32'h62);
        end
    endtask

    typedef struct {
        logic [7:0] idx;
        int         len;
        logic [7:0] ack;
        logic       exp_err;
        int         exp_frames;
        int         exp_rdy;
        int         exp_done;
    } vec_t;

    vec_t vt [4];

    initial begin
        int n;
        vt[0] = '{8'h01, 4, 8'h4B, 1'b0, 4 + NST, 4, 1};
        vt[1] = '{8'h07, 0, 8'h4B, 1'b0, 4 + NST, 0, 1};
        vt[2] = '{8'h02, 2, 8'h00, 1'b1, 1,       0, 0};
        vt[3] = '{8'h03, 1, 8'h4B, 1'b0, 4 + NST, 1, 1};
        payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
        payload[4] = 8'h01; payload[5] = 8'h23; payload[6] = 8'h45; payload[7] = 8'h67;
        for (int i = 8; i < 16; i++) payload[i] = 8'(i);

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_sck", 32'(SPI_SCK), 0);
        chk("rst_ss2", 32'(SPI_SS2), 1);
        chk("rst_di", 32'(SPI_DI), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        // Table-driven transfers: normal, length 0, ping NAK, recovery after NAK
        for (int v = 0; v < 4; v++) begin
            start_xfer(vt[v].idx, vt[v].len, vt[v].ack, -1);
            wait_idle();
            check_xfer(vt[v].idx, vt[v].len, vt[v].exp_err, vt[v].exp_frames,
                       vt[v].exp_rdy, vt[v].exp_done);
        end

        // s_valid withheld before payload byte 2
        n = stall_samp;
        start_xfer(8'h09, 3, 8'h4B, 2);
        wait_idle();
        check_xfer(8'h09, 3, 1'b0, 4 + NST, 3, 1);
        chk("stall_observed", 32'(stall_samp > n), 1);
        chk("stall_sck_ss2_low", stall_bad, 0);

        // Reset during payload byte 2 of an 8-byte stream
        start_xfer(8'h11, 8, 8'h4B, -1);
        n = 0;
        while ((rdy_cnt - rdy_base) < 3 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("reach_payload_byte2", 32'(n < 3000), 1);
        repeat (6) @(negedge clk_sys);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ss2", 32'(SPI_SS2), 1);
        chk("abort_sck", 32'(SPI_SCK), 0);
        chk("abort_busy", 32'(busy), 0);
        @(posedge clk_sys); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("abort_frames", nframes, 3 + NST);
        chk("abort_last_cmd", 32'(fb[2 + NST][0]), 32'h61);
        for (int i = 0; i < nframes; i++)
            chk($sformatf("abort_no_end_f%0d", i), 32'(fb[i][0] == 8'h62), 0);

        // Normal transfer after reset
        start_xfer(vt[0].idx, vt[0].len, vt[0].ack, -1);
        wait_idle();
        check_xfer(vt[0].idx, vt[0].len, vt[0].exp_err, vt[0].exp_frames,
                   vt[0].exp_rdy, vt[0].exp_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
